regfile_access_arbiter: RTL and testbench
=========================================

Name: regfile_access_arbiter

Overview:
- Initiator side of the register-file port.
- Collects operand-read requests from issue and write-back requests from LSB/commit.
- Serializes both onto the single register-file port: one read pair or one write per cycle.
- Returns operands one cycle later, with x0 handling and forwarding from queued, not-yet-written results.

Parameters:
WQ_DEPTH, 4, write-back queue entries (power of two, >=2)
TAG_W, 4, width of read-request tag returned with response

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global enable; low = full stall, no state change
rd_req_valid  input  1  operand read request
rd_req_ready  output  1  read accepted when valid&ready&rdy_in
rd_req_rs1  input  5  source register 1
rd_req_rs2  input  5  source register 2
rd_req_tag  input  TAG_W  requester tag
rd_resp_valid  output  1  one-cycle response pulse
rd_resp_rs1  output  32  operand 1
rd_resp_rs2  output  32  operand 2
rd_resp_tag  output  TAG_W  echoed tag
wb_valid  input  1  write-back request
wb_ready  output  1  write-back accepted when valid&ready&rdy_in
wb_rd  input  5  destination register
wb_data  input  32  result
rf_read  output  1  register-file read strobe, two operands
rf_rs1  output  5  register-file read address 1
rf_rs2  output  5  register-file read address 2
rf_write  output  1  register-file write strobe
rf_rd  output  5  register-file write address
rf_wdata  output  32  register-file write data
rf_rs1_data  input  32  register-file read data 1, valid the cycle after rf_read
rf_rs2_data  input  32  register-file read data 2, valid the cycle after rf_read

Behaviour:
Reset:
- Queue empties: count=0, pointers=0.
- rd_resp_valid=0, rd_resp_rs1/rs2=0, rd_resp_tag=0.
- rf_read=0, rf_write=0.
- Mid-operation reset discards queued writes and any in-flight response; the next cycle shows rd_resp_valid=0.

Stall:
- When rdy_in=0, both ready outputs are 0 and rf_read/rf_write are 0.
- All state holds, including a pending response.
- rd_resp_valid holds its value; the consumer qualifies it with rdy_in.

Write queue (FIFO):
- Circular buffer of WQ_DEPTH entries holding {rd, data}.
- wb_ready = (count != WQ_DEPTH).
- wb_rd=0 is accepted but not enqueued (silently dropped).
- Enqueue and dequeue in the same cycle are allowed; count is unchanged.
- Pointers wrap modulo WQ_DEPTH.

Port arbitration (combinational, per cycle):
- Queue full: issue head write (rf_write=1). rd_req_ready=0.
- Else if rd_req_valid: issue read (rf_read=1, rf_rs1/rf_rs2 = request). rd_req_ready=1. No write this cycle.
- Else if queue non-empty: issue head write. Dequeue.
- rf_read and rf_write are never both 1.

Forwarding and latency:
- A read accepted in cycle T produces rd_resp_valid=1 in T+1 for exactly one cycle, tag echoed.
- In cycle T, each source is compared against:
  - all valid queue entries;
  - a wb accepted in cycle T. This wb counts as older than the read and younger than all queue entries.
- The youngest match wins. Its data and a hit flag are registered.
- In T+1, each operand = hit ? forwarded data : rf_rsN_data.
- A source of 0 always returns 0, regardless of matches.
- Writes issued in cycle T-1 or earlier are in the register file by T, so no forwarding is needed for them.

Throughput:
- Back-to-back reads give one response per cycle.
- Continuous reads with a non-empty, non-full queue starve writes only until the queue fills; the full condition then forces drain.

Test Plan:
- Reset, then write x5=0x1234 via wb; idle 2 cycles; read rs1=5, rs2=0 -> rf_write cycle 1 with rd=5; response next cycle after read: rs1=0x1234, rs2=0, tag echoed.
- Same-cycle wb x7=0xAAAA and read rs1=7 -> rf_read issued, write stays queued; response rs1=0xAAAA with rf_rs1_data driven 0xDEAD (forwarded).
- Queue two writes x3=1 then x3=2, read rs1=3 before drain -> rs1=2 (youngest wins).
- Hold rd_req_valid high and push 4 writes -> after count=4, rd_req_ready=0 and wb_ready=0, one write issued, then reads resume; all 4 writes eventually appear on rf port in order.
- wb to x0 with data 0xFFFF -> no rf_write ever; read rs1=0 -> 0.
- rdy_in=0 for 3 cycles with a pending response and a queued write -> no rf strobes, response and queue unchanged; rst_in pulse mid-traffic -> rd_resp_valid=0, wb_ready=1, no rf_write next cycle.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Register-file port initiator: serializes operand reads and queued write-backs onto one port,
// returning operands a cycle later with forwarding from not-yet-written results.
module regfile_access_arbiter #(
   parameter int WQ_DEPTH = 4,
   parameter int TAG_W    = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             rd_req_valid,
   output logic             rd_req_ready,
   input  logic [4:0]       rd_req_rs1,
   input  logic [4:0]       rd_req_rs2,
   input  logic [TAG_W-1:0] rd_req_tag,
   output logic             rd_resp_valid,
   output logic [31:0]      rd_resp_rs1,
   output logic [31:0]      rd_resp_rs2,
   output logic [TAG_W-1:0] rd_resp_tag,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   output logic             rf_read,
   output logic [4:0]       rf_rs1,
   output logic [4:0]       rf_rs2,
   output logic             rf_write,
   output logic [4:0]       rf_rd,
   output logic [31:0]      rf_wdata,
   input  logic [31:0]      rf_rs1_data,
   input  logic [31:0]      rf_rs2_data
);

   localparam int PTR_W = $clog2(WQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]       q_rd   [WQ_DEPTH];
   logic [31:0]      q_data [WQ_DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             full, empty;
   logic             rd_fire, wb_fire, enq;

   logic             hit1_p0, hit2_p0;
   logic [31:0]      fwd1_p0, fwd2_p0;
   logic             vld_p1, hit1_p1, hit2_p1;
   logic [31:0]      fwd1_p1, fwd2_p1;
   logic [TAG_W-1:0] tag_p1;

   // p0: arbitration and forwarding lookup in the request cycle
   assign full         = (count == CNT_W'(WQ_DEPTH));
   assign empty        = (count == '0);
   assign wb_ready     = rdy_in & ~full;
   assign rd_req_ready = rdy_in & ~full;
   assign rd_fire      = rd_req_valid & rd_req_ready;
   assign wb_fire      = wb_valid & wb_ready;
   assign enq          = wb_fire & (wb_rd != 5'd0);

   assign rf_read  = rd_fire;
   assign rf_rs1   = rd_req_rs1;
   assign rf_rs2   = rd_req_rs2;
   assign rf_write = rdy_in & (full | (~rd_req_valid & ~empty));
   assign rf_rd    = q_rd[head];
   assign rf_wdata = q_data[head];

   // Entries are scanned oldest to youngest so the last match wins; the incoming wb is youngest.
   always_comb begin
      hit1_p0 = 1'b0;
      hit2_p0 = 1'b0;
      fwd1_p0 = '0;
      fwd2_p0 = '0;
      for (int i = 0; i < WQ_DEPTH; i++) begin
         if (CNT_W'(i) < count) begin
            if (q_rd[head + PTR_W'(i)] == rd_req_rs1) begin
               hit1_p0 = 1'b1;
               fwd1_p0 = q_data[head + PTR_W'(i)];
            end
            if (q_rd[head + PTR_W'(i)] == rd_req_rs2) begin
               hit2_p0 = 1'b1;
               fwd2_p0 = q_data[head + PTR_W'(i)];
            end
         end
      end
      if (enq && (wb_rd == rd_req_rs1)) begin
         hit1_p0 = 1'b1;
         fwd1_p0 = wb_data;
      end
      if (enq && (wb_rd == rd_req_rs2)) begin
         hit2_p0 = 1'b1;
         fwd2_p0 = wb_data;
      end
      if (rd_req_rs1 == 5'd0) begin
         hit1_p0 = 1'b1;
         fwd1_p0 = '0;
      end
      if (rd_req_rs2 == 5'd0) begin
         hit2_p0 = 1'b1;
         fwd2_p0 = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         vld_p1  <= 1'b0;
         hit1_p1 <= 1'b0;
         hit2_p1 <= 1'b0;
         tag_p1  <= '0;
      end else if (rdy_in) begin
         if (enq) tail <= tail + PTR_W'(1);
         if (rf_write) head <= head + PTR_W'(1);
         count  <= count + CNT_W'(enq) - CNT_W'(rf_write);
         vld_p1 <= rd_fire;
         if (rd_fire) begin
            hit1_p1 <= hit1_p0;
            hit2_p1 <= hit2_p0;
            tag_p1  <= rd_req_tag;
         end
      end else if (vld_p1) begin
         // The RF read data is only guaranteed for one cycle, so a stalled response is captured.
         hit1_p1 <= 1'b1;
         hit2_p1 <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         if (enq) begin
            q_rd[tail]   <= wb_rd;
            q_data[tail] <= wb_data;
         end
         if (rd_fire) begin
            fwd1_p1 <= fwd1_p0;
            fwd2_p1 <= fwd2_p0;
         end
      end else if (vld_p1) begin
         fwd1_p1 <= rd_resp_rs1;
         fwd2_p1 <= rd_resp_rs2;
      end
   end

   // p1: operand select against the register-file read data
   assign rd_resp_valid = vld_p1;
   assign rd_resp_rs1   = vld_p1 ? (hit1_p1 ? fwd1_p1 : rf_rs1_data) : '0;
   assign rd_resp_rs2   = vld_p1 ? (hit2_p1 ? fwd2_p1 : rf_rs2_data) : '0;
   assign rd_resp_tag   = tag_p1;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: architectural register model plus a register-file model,
// directed scenarios with literal expectations followed by randomized traffic.
module tb_regfile_access_arbiter;

   localparam int WQ_DEPTH = 4;
   localparam int TAG_W    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rdy = 1'b1;
   logic             rd_req_valid = 1'b0;
   logic             rd_req_ready;
   logic [4:0]       rs1 = '0, rs2 = '0;
   logic [TAG_W-1:0] tag = '0;
   logic             rd_resp_valid;
   logic [31:0]      rd_resp_rs1, rd_resp_rs2;
   logic [TAG_W-1:0] rd_resp_tag;
   logic             wb_valid = 1'b0;
   logic             wb_ready;
   logic [4:0]       wb_rd = '0;
   logic [31:0]      wb_data = '0;
   logic             rf_read, rf_write;
   logic [4:0]       rf_rs1, rf_rs2, rf_rd;
   logic [31:0]      rf_wdata;
   logic [31:0]      rf_rs1_data = '0, rf_rs2_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_access_arbiter #(.WQ_DEPTH(WQ_DEPTH), .TAG_W(TAG_W)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_rs1(rs1), .rd_req_rs2(rs2), .rd_req_tag(tag),
      .rd_resp_valid(rd_resp_valid), .rd_resp_rs1(rd_resp_rs1),
      .rd_resp_rs2(rd_resp_rs2), .rd_resp_tag(rd_resp_tag),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_read(rf_read), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_write(rf_write), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data)
   );

   function automatic logic [31:0] init_val(input int r);
      return (r == 7) ? 32'h0000_DEAD : 32'h1000_0000 + 32'(r) * 32'h0101_0101;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Register-file model: writes land at the clock edge, read data appears the next cycle.
   logic [31:0] rfmem [32];
   logic        rf_init_done = 1'b0;
   always @(posedge clk) begin
      if (!rf_init_done) begin
         for (int r = 0; r < 32; r++) rfmem[r] <= init_val(r);
         rf_init_done <= 1'b1;
      end else begin
         if (rf_write === 1'b1) rfmem[rf_rd] <= rf_wdata;
         if (rf_read === 1'b1) begin
            rf_rs1_data <= rfmem[rf_rs1];
            rf_rs2_data <= rfmem[rf_rs2];
         end
      end
   end

   // Architectural model: arch holds the value every accepted write-back gives a register,
   // wq holds accepted writes in order that have not yet gone out on the port.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t              wq[$];
   logic [31:0]      arch [32];
   bit               arch_init = 1'b0;
   bit               model_on  = 1'b0;
   bit               exp_vld   = 1'b0;
   logic [31:0]      exp_rs1 = '0, exp_rs2 = '0;
   logic [TAG_W-1:0] exp_tag = '0;
   bit               m_full, m_rd_fire, m_wr_issue;

   always @(negedge clk) begin
      if (!arch_init) begin
         for (int r = 0; r < 32; r++) arch[r] = init_val(r);
         arch_init = 1'b1;
      end
      if (model_on) begin
         chk("resp_valid", 32'(rd_resp_valid), 32'(exp_vld));
         if (exp_vld) begin
            chk("resp_rs1", rd_resp_rs1, exp_rs1);
            chk("resp_rs2", rd_resp_rs2, exp_rs2);
            chk("resp_tag", 32'(rd_resp_tag), 32'(exp_tag));
         end
         m_full     = (wq.size() == WQ_DEPTH);
         m_rd_fire  = rdy && rd_req_valid && !m_full;
         m_wr_issue = rdy && (m_full || (!rd_req_valid && wq.size() != 0));
         chk("wb_ready", 32'(wb_ready), 32'(rdy && !m_full));
         chk("rd_req_ready", 32'(rd_req_ready), 32'(rdy && !m_full));
         chk("rf_read", 32'(rf_read), 32'(m_rd_fire));
         chk("rf_write", 32'(rf_write), 32'(m_wr_issue));
         if (m_wr_issue) begin
            chk("rf_rd", 32'(rf_rd), 32'(wq[0].rd));
            chk("rf_wdata", rf_wdata, wq[0].data);
         end
         if (m_rd_fire) begin
            chk("rf_rs1", 32'(rf_rs1), 32'(rs1));
            chk("rf_rs2", 32'(rf_rs2), 32'(rs2));
         end
         if (rst) begin
            for (int r = 0; r < 32; r++) arch[r] = rfmem[r];
            if (m_wr_issue) arch[wq[0].rd] = wq[0].data;
            wq.delete();
            exp_vld = 1'b0;
            exp_rs1 = '0;
            exp_rs2 = '0;
            exp_tag = '0;
         end else if (rdy) begin
            if (wb_valid && !m_full && wb_rd != 5'd0) begin
               arch[wb_rd] = wb_data;
               wq.push_back('{wb_rd, wb_data});
            end
            exp_vld = m_rd_fire;
            if (m_rd_fire) begin
               exp_rs1 = (rs1 == 5'd0) ? 32'd0 : arch[rs1];
               exp_rs2 = (rs2 == 5'd0) ? 32'd0 : arch[rs2];
               exp_tag = tag;
            end
            if (m_wr_issue) void'(wq.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [TAG_W-1:0] t);
      rd_req_valid = v;
      rs1 = a;
      rs2 = b;
      tag = t;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
      wb_valid = v;
      wb_rd = r;
      wb_data = d;
   endtask

   initial begin
      int rd_pct, wb_pct;
      cyc();
      model_on = 1'b1;
      @(negedge clk);
      chk("reset_resp_valid", 32'(rd_resp_valid), 32'd0);
      chk("reset_resp_rs1", rd_resp_rs1, 32'd0);
      chk("reset_resp_tag", 32'(rd_resp_tag), 32'd0);
      chk("reset_rf_write", 32'(rf_write), 32'd0);
      chk("reset_wb_ready", 32'(wb_ready), 32'd1);
      cyc();
      rst = 1'b0;

      // Write x5, let it drain, read it back
      set_wb(1, 5'd5, 32'h1234);
      cyc();
      set_wb(0, 0, 0);
      @(negedge clk);
      chk("drain_rf_write", 32'(rf_write), 32'd1);
      chk("drain_rf_rd", 32'(rf_rd), 32'd5);
      chk("drain_rf_wdata", rf_wdata, 32'h1234);
      cyc();
      cyc();
      set_rd(1, 5'd5, 5'd0, 4'd3);
      @(negedge clk);
      chk("read_rf_read", 32'(rf_read), 32'd1);
      cyc();
      set_rd(0, 0, 0, 0);
      @(negedge clk);
      chk("x5_resp_valid", 32'(rd_resp_valid), 32'd1);
      chk("x5_resp_rs1", rd_resp_rs1, 32'h1234);
      chk("x5_resp_rs2", rd_resp_rs2, 32'd0);
      chk("x5_resp_tag", 32'(rd_resp_tag), 32'd3);
      cyc();

      // Same-cycle write-back forwarded over stale register-file data
      set_wb(1, 5'd7, 32'hAAAA);
      set_rd(1, 5'd7, 5'd0, 4'd5);
      @(negedge clk);
      chk("samecyc_rf_read", 32'(rf_read), 32'd1);
      chk("samecyc_rf_write", 32'(rf_write), 32'd0);
      cyc();
      set_wb(0, 0, 0);
      set_rd(0, 0, 0, 0);
      @(negedge clk);
      chk("samecyc_rs1", rd_resp_rs1, 32'hAAAA);
      chk("samecyc_tag", 32'(rd_resp_tag), 32'd5);
      cyc();

      // Two queued writes to x3: youngest wins
      set_wb(1, 5'd3, 32'd1);
      set_rd(1, 5'd0, 5'd0, 4'd1);
      cyc();
      set_wb(1, 5'd3, 32'd2);
      set_rd(1, 5'd9, 5'd9, 4'd2);
      cyc();
      set_wb(0, 0, 0);
      set_rd(1, 5'd3, 5'd3, 4'd7);
      cyc();
      set_rd(0, 0, 0, 0);
      @(negedge clk);
      chk("youngest_rs1", rd_resp_rs1, 32'd2);
      chk("youngest_rs2", rd_resp_rs2, 32'd2);
      chk("youngest_tag", 32'(rd_resp_tag), 32'd7);
      for (int i = 0; i < 4; i++) cyc();

      // Continuous reads fill the queue, then the full queue forces a drain
      for (int i = 0; i < 4; i++) begin
         set_rd(1, 5'(10 + i), 5'd1, 4'(i));
         set_wb(1, 5'(10 + i), 32'h100 + 32'(i));
         cyc();
      end
      set_wb(0, 0, 0);
      set_rd(1, 5'd10, 5'd11, 4'd8);
      @(negedge clk);
      chk("full_rd_ready", 32'(rd_req_ready), 32'd0);
      chk("full_wb_ready", 32'(wb_ready), 32'd0);
      chk("full_rf_write", 32'(rf_write), 32'd1);
      chk("full_rf_rd", 32'(rf_rd), 32'd10);
      chk("full_rf_wdata", rf_wdata, 32'h100);
      cyc();
      @(negedge clk);
      chk("resume_rd_ready", 32'(rd_req_ready), 32'd1);
      chk("resume_rf_read", 32'(rf_read), 32'd1);
      cyc();
      set_rd(0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc();

      // Write-back to x0 is dropped
      set_wb(1, 5'd0, 32'hFFFF);
      @(negedge clk);
      chk("x0_wb_ready", 32'(wb_ready), 32'd1);
      cyc();
      set_wb(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("x0_no_write", 32'(rf_write), 32'd0);
         cyc();
      end
      set_rd(1, 5'd0, 5'd0, 4'd9);
      cyc();
      set_rd(0, 0, 0, 0);
      @(negedge clk);
      chk("x0_resp_rs1", rd_resp_rs1, 32'd0);
      cyc();

      // Stall with a pending response and a queued write
      set_rd(1, 5'd5, 5'd7, 4'd4);
      set_wb(1, 5'd20, 32'h5555);
      cyc();
      set_rd(0, 0, 0, 0);
      set_wb(0, 0, 0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rf_read", 32'(rf_read), 32'd0);
         chk("stall_rf_write", 32'(rf_write), 32'd0);
         chk("stall_resp_valid", 32'(rd_resp_valid), 32'd1);
         chk("stall_resp_rs1", rd_resp_rs1, 32'h1234);
         chk("stall_resp_rs2", rd_resp_rs2, 32'hAAAA);
         chk("stall_resp_tag", 32'(rd_resp_tag), 32'd4);
         cyc();
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("unstall_rf_write", 32'(rf_write), 32'd1);
      chk("unstall_rf_rd", 32'(rf_rd), 32'd20);
      cyc();

      // Reset in the middle of traffic
      set_rd(1, 5'd20, 5'd1, 4'd6);
      set_wb(1, 5'd21, 32'd1);
      cyc();
      set_wb(1, 5'd22, 32'd2);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_rd(0, 0, 0, 0);
      set_wb(0, 0, 0);
      @(negedge clk);
      chk("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd1);
      chk("rst_rf_write", 32'(rf_write), 32'd0);
      cyc();

      // Randomized traffic against the model
      rd_pct = 50;
      wb_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 0) begin
            rd_pct = $urandom_range(10, 95);
            wb_pct = $urandom_range(10, 95);
         end
         rst = ($urandom_range(0, 299) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         set_rd($urandom_range(0, 99) < rd_pct, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 4'($urandom));
         set_wb($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 7)), $urandom);
         cyc();
      end
      rst = 1'b0;
      rdy = 1'b1;
      set_rd(0, 0, 0, 0);
      set_wb(0, 0, 0);
      for (int i = 0; i < 8; i++) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
